ifetch_queue: RTL

- Consumer side of the PC register's `pc` / `pc_en` interface.
- Takes the current PC, issues in-order requests to instruction memory, and pairs each response with its PC in a small queue.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Drives `pc_en` back to the PC register, so the PC stalls whenever the queue or memory cannot accept a request.
- Sits between the PC register and the decode stage.

---
 rtl/ifetch_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch queue between the PC register and decode. Issues
//   in-order instruction memory requests at the current PC, pairs each
//   response with the PC that requested it, and presents {pc, instr} to
//   decode through a valid/ready handshake. pc_en stalls the PC register
//   whenever a request cannot be issued.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   pc / pc_en             current PC in, advance enable out (= request accepted)
//   flush                  redirect: drop queued and in-flight fetches
//   imem_req_valid/ready   request handshake, imem_addr = pc
//   imem_rsp_valid/data    in-order responses
//   if_valid/ready         head entry handshake to decode
//   if_pc / if_instr       head entry contents (RESET_PC / NOP when empty)
//
// Optional build macro IFQ_PERF_CNT_EN adds stall_cnt and drop_cnt_total.

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
`ifdef IFQ_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] drop_cnt_total,
`endif
  output logic [31:0] if_instr
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C  = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q,  fill_d;
  logic [PW-1:0] head_q,  head_d;
  logic [PW:0]   occ_q,   occ_d;
  // Requests accepted but not yet answered (excludes ones already marked for drop).
  logic [PW:0]   infl_q,  infl_d;
  logic [PW:0]   drop_q,  drop_d;

  logic full, empty, accept, rsp_store, rsp_drop, pop;

  assign full  = (occ_q == FULL_C);
  assign empty = (occ_q == '0);

  // rst_n gating keeps the request strobe low while reset is held.
  assign imem_req_valid = rst_n && !flush && !full;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_en          = accept;

  assign rsp_store = imem_rsp_valid && !flush && (drop_q == '0);
  assign rsp_drop  = imem_rsp_valid && (flush || (drop_q != '0));

  assign if_valid = filled_q[head_q] && !empty;
  assign if_pc    = empty ? RESET_PC : pc_q[head_q];
  assign if_instr = empty ? NOP      : instr_q[head_q];
  assign pop      = if_valid && if_ready && !flush;

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    occ_d   = occ_q;
    infl_d  = infl_q;
    drop_d  = drop_q;
    if (flush) begin
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      occ_d   = '0;
      infl_d  = '0;
      // Everything still owed by memory must be discarded; a response
      // arriving right now is discarded immediately.
      drop_d  = drop_q + infl_q - (PW+1)'(imem_rsp_valid);
    end else begin
      alloc_d = alloc_q + PW'(accept);
      fill_d  = fill_q + PW'(rsp_store);
      head_d  = head_q + PW'(pop);
      occ_d   = occ_q + (PW+1)'(accept) - (PW+1)'(pop);
      infl_d  = infl_q + (PW+1)'(accept) - (PW+1)'(rsp_store);
      drop_d  = drop_q - (PW+1)'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
    end
  end

  // Accept, fill and pop always address distinct entries, so their
  // updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled_q <= '0;
    end else if (flush) begin
      filled_q <= '0;
    end else begin
      if (accept)    filled_q[alloc_q] <= 1'b0;
      if (rsp_store) filled_q[fill_q]  <= 1'b1;
      if (pop)       filled_q[head_q]  <= 1'b0;
    end
  end

  // Payload needs no reset: it is only visible through filled/occupancy.
  always_ff @(posedge clk) begin
    if (accept)    pc_q[alloc_q]   <= pc;
    if (rsp_store) instr_q[fill_q] <= imem_rsp_data;
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt      <= '0;
      drop_cnt_total <= '0;
    end else begin
      if (!flush && !pc_en) stall_cnt      <= stall_cnt + 32'd1;
      if (rsp_drop)         drop_cnt_total <= drop_cnt_total + 32'd1;
    end
  end
`endif

endmodule
